red_pitaya_na_sweep_block: RTL and testbench
============================================

Name: red_pitaya_na_sweep_block

Overview:
Network-analyzer sweep sequencer placed directly downstream of the IQ demodulator/low-pass stage.
- Steps the IQ reference phase increment over a programmed frequency list.
- Waits a settling time at each point, then accumulates the two filtered quadratures over N samples.
- Pushes each point's I/Q result into a result FIFO that the PS drains over the system bus.
- phase_inc_o drives the IQ block's shift-phase increment, so a whole sweep runs without per-point software writes.

Parameters:
QUADBITS, 24, width of signed quadrature inputs
PHASEBITS, 32, phase-increment width
SUMBITS, 56, internal signed accumulator width
OUTSHIFT, 16, right shift applied to each sum before storing it
FIFOAW, 4, log2 of FIFO depth (16 entries of I+Q)

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous reset, active low
quad1_i  in  QUADBITS  signed low-passed I quadrature
quad2_i  in  QUADBITS  signed low-passed Q quadrature
phase_inc_o  out  PHASEBITS  current frequency word to the IQ fgen
freq_update_o  out  1  one-cycle pulse when phase_inc_o changes
busy_o  out  1  sweep in progress
addr  in  16  bus address
wen  in  1  bus write strobe
ren  in  1  bus read strobe
ack  out  1  bus acknowledge, registered
rdata  out  32  bus read data, registered
wdata  in  32  bus write data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rstn_i. Reset puts the FSM in IDLE, empties the FIFO, and clears all registers and outputs, including phase_inc_o, freq_update_o, busy_o, ack and rdata. Reset mid-sweep aborts the sweep immediately.
- Register map:
  - 0x00 ctrl: write bit0=1 starts a sweep, bit1=1 aborts. Reads return {busy, overflow}.
  - 0x04 start_freq
  - 0x08 step (unsigned; increments wrap modulo 2^PHASEBITS)
  - 0x0C points
  - 0x10 averages
  - 0x14 sleepcycles
  - 0x18 status: {fifo_count[FIFOAW:0], fifo_empty, fifo_full}
  - 0x20 reads the head I result without popping.
  - 0x24 reads the head Q result and pops the entry.
  - Other addresses read 0.
- Bus timing: ack <= wen|ren one cycle after the strobe for every address. rdata is valid in the same cycle as ack.
- FSM states:
  - IDLE: on a start write with points!=0, load freq=start_freq and pts_left=points, clear overflow, go to SETFREQ. Start with points=0 is ignored. Start while busy is ignored.
  - SETFREQ (1 cycle): phase_inc_o<=freq, pulse freq_update_o, load sleep_cnt=sleepcycles, load avg_cnt=max(averages,1), clear both sums, go to SLEEP.
  - SLEEP: decrement sleep_cnt; go to AVERAGE when it reaches 0. sleepcycles=0 means zero wait cycles.
  - AVERAGE: on each cycle add sign-extended quad1_i/quad2_i to sumI/sumQ and decrement avg_cnt. Exactly max(averages,1) samples are accumulated. Go to STORE after the last sample.
  - STORE: if the FIFO is not full, push {satI, satQ}, decrement pts_left, and go to SETFREQ with freq+=step, or to IDLE if pts_left becomes 0. If the FIFO is full, stay in STORE and set overflow=1 (sticky); no data is lost, the sweep stalls.
  - Abort (any state): return to IDLE next cycle. No push. FIFO contents are kept.
- Arithmetic: each stored value is sum>>>OUTSHIFT (arithmetic shift), saturated to the signed 32-bit range.
- busy_o=1 in every state except IDLE.
- Pop on an empty FIFO: no effect, returns 0. Reading 0x20 when empty returns 0.
- Same-cycle push and pop with the FIFO full: the pop happens first and the push succeeds.
- Latency from the last accumulated sample to the FIFO entry being visible in status: 2 cycles.
- phase_inc_o holds its last value after the sweep ends or is aborted.

Test Plan:
- Sweep 1: start=1000, step=10, points=3, averages=4, sleep=2, quad1=+100, quad2=-50, OUTSHIFT=0 -> phase_inc_o takes 1000, 1010, 1020, with one freq_update_o pulse each; FIFO holds three entries of (400, -200); busy_o falls after the 3rd push.
- Timing: sleep=5, averages=1 -> exactly 5 SLEEP cycles; the accumulated sample is the one 6 cycles after the freq_update_o pulse.
- Full FIFO: points=20 with no reads -> stalls after 16 entries with overflow=1; one 0x24 read lets entry 17 in; draining completes all 20 entries in order.
- Saturation: quad1=max positive (2^23-1), averages=2^20, OUTSHIFT=0 -> stored I=0x7FFFFFFF; with quad1 negative full-scale, stored I=0x80000000.
- Edge cases: points=0 start -> busy_o stays 0; averages=0 -> one sample accumulated; step wraps from 0xFFFFFFF0 by 0x20 to 0x10.
- Interruptions: abort during AVERAGE -> IDLE next cycle, no push; rstn_i low mid-sweep -> all outputs 0 and FIFO empty on the next cycle.

Source files
------------

// File: rtl/red_pitaya_na_sweep_block.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_na_sweep_block
// Brief    : Network-analyzer sweep sequencer: steps the IQ phase increment,
//            settles, averages both quadratures and queues I/Q for the PS.
// Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_na_sweep_block #(
  parameter int QUADBITS  = 24,
  parameter int PHASEBITS = 32,
  parameter int SUMBITS   = 56,
  parameter int OUTSHIFT  = 16,
  parameter int FIFOAW    = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic signed [QUADBITS-1:0] quad1_i,
  input  logic signed [QUADBITS-1:0] quad2_i,
  output logic [PHASEBITS-1:0]       phase_inc_o,
  output logic                       freq_update_o,
  output logic                       busy_o,
  input  logic [15:0]                addr,
  input  logic                       wen,
  input  logic                       ren,
  output logic                       ack,
  output logic [31:0]                rdata,
  input  logic [31:0]                wdata
);

  localparam logic [15:0] c_ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] c_ADDR_START  = 16'h0004;
  localparam logic [15:0] c_ADDR_STEP   = 16'h0008;
  localparam logic [15:0] c_ADDR_POINTS = 16'h000C;
  localparam logic [15:0] c_ADDR_AVG    = 16'h0010;
  localparam logic [15:0] c_ADDR_SLEEP  = 16'h0014;
  localparam logic [15:0] c_ADDR_STATUS = 16'h0018;
  localparam logic [15:0] c_ADDR_FIFO_I = 16'h0020;
  localparam logic [15:0] c_ADDR_FIFO_Q = 16'h0024;
  localparam int          c_DEPTH       = 2**FIFOAW;
  localparam logic [FIFOAW-1:0] c_PTR_ONE = 1;
  localparam logic [FIFOAW:0]   c_CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETFREQ = 3'd1,
    S_SLEEP   = 3'd2,
    S_AVERAGE = 3'd3,
    S_STORE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PHASEBITS-1:0]      r_start_freq;
  logic [PHASEBITS-1:0]      r_step;
  logic [PHASEBITS-1:0]      r_freq;
  logic [31:0]               r_points;
  logic [31:0]               r_averages;
  logic [31:0]               r_sleepcycles;
  logic [31:0]               r_pts_left;
  logic [31:0]               r_sleep_cnt;
  logic [31:0]               r_avg_cnt;
  logic signed [SUMBITS-1:0] r_sum_i;
  logic signed [SUMBITS-1:0] r_sum_q;
  logic                      r_overflow;

  logic [63:0]               r_mem [c_DEPTH];
  logic [FIFOAW-1:0]         r_wptr;
  logic [FIFOAW-1:0]         r_rptr;
  logic [FIFOAW:0]           r_count;

  logic                      w_ctrl_wr;
  logic                      w_abort;
  logic                      w_start;
  logic                      w_go;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic [31:0]               w_avg_eff;
  logic signed [SUMBITS-1:0] w_q1_ext;
  logic signed [SUMBITS-1:0] w_q2_ext;
  logic [31:0]               w_sat_i;
  logic [31:0]               w_sat_q;
  logic [31:0]               w_head_i;
  logic [31:0]               w_head_q;
  logic [31:0]               w_rd_mux;

  // Arithmetic shift, then clamp anything outside the signed 32-bit range.
  function automatic logic [31:0] f_sat(input logic signed [SUMBITS-1:0] i_sum);
    logic signed [SUMBITS-1:0] w_sh;
    logic [SUMBITS-32:0]       w_hi;
    w_sh = i_sum >>> OUTSHIFT;
    w_hi = w_sh[SUMBITS-1:31];
    if ((&w_hi) || !(|w_hi)) return w_sh[31:0];
    else if (w_sh[SUMBITS-1]) return 32'h8000_0000;
    else return 32'h7FFF_FFFF;
  endfunction

  assign w_ctrl_wr = wen && (addr == c_ADDR_CTRL);
  assign w_abort   = w_ctrl_wr && wdata[1];
  assign w_start   = w_ctrl_wr && wdata[0] && !wdata[1];
  assign w_go      = (r_state == S_IDLE) && w_start && (r_points != 32'd0);

  assign w_empty   = (r_count == '0);
  assign w_full    = r_count[FIFOAW];
  assign w_pop     = ren && (addr == c_ADDR_FIFO_Q) && !w_empty;
  // A pop in the same cycle frees the slot a stalled STORE is waiting for.
  assign w_push    = (r_state == S_STORE) && !w_abort && (!w_full || w_pop);

  assign w_avg_eff = (r_averages == 32'd0) ? 32'd1 : r_averages;
  assign w_q1_ext  = {{(SUMBITS-QUADBITS){quad1_i[QUADBITS-1]}}, quad1_i};
  assign w_q2_ext  = {{(SUMBITS-QUADBITS){quad2_i[QUADBITS-1]}}, quad2_i};
  assign w_sat_i   = f_sat(r_sum_i);
  assign w_sat_q   = f_sat(r_sum_q);
  assign w_head_i  = w_empty ? 32'd0 : r_mem[r_rptr][63:32];
  assign w_head_q  = w_empty ? 32'd0 : r_mem[r_rptr][31:0];
  assign busy_o    = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_go) w_state_nxt = S_SETFREQ;
        S_SETFREQ: w_state_nxt = (r_sleepcycles == 32'd0) ? S_AVERAGE : S_SLEEP;
        S_SLEEP:   if (r_sleep_cnt == 32'd1) w_state_nxt = S_AVERAGE;
        S_AVERAGE: if (r_avg_cnt == 32'd1) w_state_nxt = S_STORE;
        S_STORE:   if (w_push) w_state_nxt = (r_pts_left == 32'd1) ? S_IDLE : S_SETFREQ;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_start_freq  <= '0;
      r_step        <= '0;
      r_points      <= '0;
      r_averages    <= '0;
      r_sleepcycles <= '0;
    end else if (wen) begin
      case (addr)
        c_ADDR_START:  r_start_freq  <= PHASEBITS'(wdata);
        c_ADDR_STEP:   r_step        <= PHASEBITS'(wdata);
        c_ADDR_POINTS: r_points      <= wdata;
        c_ADDR_AVG:    r_averages    <= wdata;
        c_ADDR_SLEEP:  r_sleepcycles <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_freq        <= '0;
      r_pts_left    <= '0;
      r_sleep_cnt   <= '0;
      r_avg_cnt     <= '0;
      r_sum_i       <= '0;
      r_sum_q       <= '0;
      r_overflow    <= 1'b0;
      phase_inc_o   <= '0;
      freq_update_o <= 1'b0;
    end else begin
      freq_update_o <= 1'b0;
      if (w_go) begin
        r_freq     <= r_start_freq;
        r_pts_left <= r_points;
        r_overflow <= 1'b0;
      end
      if (!w_abort) begin
        case (r_state)
          S_SETFREQ: begin
            phase_inc_o   <= r_freq;
            freq_update_o <= 1'b1;
            r_sleep_cnt   <= r_sleepcycles;
            r_avg_cnt     <= w_avg_eff;
            r_sum_i       <= '0;
            r_sum_q       <= '0;
          end
          S_SLEEP: r_sleep_cnt <= r_sleep_cnt - 32'd1;
          S_AVERAGE: begin
            r_sum_i   <= r_sum_i + w_q1_ext;
            r_sum_q   <= r_sum_q + w_q2_ext;
            r_avg_cnt <= r_avg_cnt - 32'd1;
          end
          S_STORE: begin
            if (w_push) begin
              r_pts_left <= r_pts_left - 32'd1;
              r_freq     <= r_freq + r_step;
            end else begin
              r_overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= {w_sat_i, w_sat_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      c_ADDR_CTRL:   w_rd_mux = {30'd0, busy_o, r_overflow};
      c_ADDR_START:  w_rd_mux = 32'(r_start_freq);
      c_ADDR_STEP:   w_rd_mux = 32'(r_step);
      c_ADDR_POINTS: w_rd_mux = r_points;
      c_ADDR_AVG:    w_rd_mux = r_averages;
      c_ADDR_SLEEP:  w_rd_mux = r_sleepcycles;
      c_ADDR_STATUS: w_rd_mux = 32'({r_count, w_empty, w_full});
      c_ADDR_FIFO_I: w_rd_mux = w_head_i;
      c_ADDR_FIFO_Q: w_rd_mux = w_head_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? w_rd_mux : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_na_sweep_block.sv
`default_nettype none
// Directed bench for red_pitaya_na_sweep_block: a point-list model predicts the
// frequency words and FIFO contents of each programmed sweep.
module tb_red_pitaya_na_sweep_block;

  localparam logic [15:0] A_CTRL = 16'h00, A_START = 16'h04, A_STEP = 16'h08;
  localparam logic [15:0] A_PTS  = 16'h0C, A_AVG   = 16'h10, A_SLEEP = 16'h14;
  localparam logic [15:0] A_STAT = 16'h18, A_FI    = 16'h20, A_FQ    = 16'h24;
  localparam int OS = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] addr = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack, freq_update, busy;
  logic [31:0] rdata, phase_inc;

  int                 quad_mode = 0;
  logic signed [23:0] q1_set = '0, q2_set = '0, ramp_q1 = '0;
  logic signed [23:0] w_quad1, w_quad2;

  int n_tests = 0, n_fail = 0;
  int tick = 0, pulse_cnt = 0, pulse_tick = 0, busy_cnt = 0;
  bit mon_en = 1'b1;
  logic [31:0] exp_freq[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // mode 0: constants, 1: per-cycle ramp on I, 2: response follows the frequency word
  always_comb begin
    w_quad1 = q1_set;
    w_quad2 = q2_set;
    if (quad_mode == 1) w_quad1 = ramp_q1;
    else if (quad_mode == 2) begin
      w_quad1 = $signed({8'd0, phase_inc[15:0]});
      w_quad2 = -w_quad1;
    end
  end

  red_pitaya_na_sweep_block #(
    .QUADBITS(24), .PHASEBITS(32), .SUMBITS(56), .OUTSHIFT(OS), .FIFOAW(4)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn), .quad1_i(w_quad1), .quad2_i(w_quad2),
    .phase_inc_o(phase_inc), .freq_update_o(freq_update), .busy_o(busy),
    .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    longint s;
    s = v >>> OS;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // Expected frequency words and FIFO entries of a whole sweep.
  task automatic plan_sweep(input logic [31:0] f0, input logic [31:0] st, input int npts, input int avg);
    logic [31:0] f;
    longint q1, q2, n;
    n = (avg == 0) ? 1 : avg;
    f = f0;
    for (int p = 0; p < npts; p++) begin
      exp_freq.push_back(f);
      if (quad_mode == 2) begin q1 = longint'(f[15:0]); q2 = -q1; end
      else begin q1 = longint'(q1_set); q2 = longint'(q2_set); end
      exp_i.push_back(sat32(n * q1));
      exp_q.push_back(sat32(n * q2));
      f = f + st;
    end
  endtask

  // Compare process: frequency word on every update pulse, plus cycle bookkeeping.
  always @(negedge clk) begin
    tick = tick + 1;
    ramp_q1 = 24'(tick);
    if (busy) busy_cnt = busy_cnt + 1;
    if (rstn && freq_update) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_tick = tick;
      if (mon_en) begin
        if (exp_freq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: phase_inc 0x%0h with no point pending", phase_inc);
        end else check("phase_inc", phase_inc, exp_freq.pop_front());
      end
    end
  end

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wen = 1'b1;
    @(negedge clk); wen = 1'b0;
    check("wr_ack", ack, 1);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; ren = 1'b1;
    @(negedge clk); ren = 1'b0; d = rdata;
    check("rd_ack", ack, 1);
  endtask

  task automatic configure(input logic [31:0] f0, st, pts, avg, slp);
    bus_wr(A_START, f0); bus_wr(A_STEP, st); bus_wr(A_PTS, pts);
    bus_wr(A_AVG, avg);  bus_wr(A_SLEEP, slp);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    end
  endtask

  task automatic pop_check();
    logic [31:0] d;
    int k;
    k = 0;
    bus_rd(A_STAT, d);
    while (d[6:2] == 5'd0 && k < 50) begin bus_rd(A_STAT, d); k++; end
    if (exp_i.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL pop_check: model has no entry left");
    end else begin
      bus_rd(A_FI, d); check("fifo_i", d, exp_i.pop_front());
      bus_rd(A_FQ, d); check("fifo_q", d, exp_q.pop_front());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int b0, p0;

    repeat (3) @(negedge clk);
    check("rst_phase", phase_inc, 0);
    check("rst_pulse", freq_update, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    rstn = 1'b1;
    bus_rd(A_STAT, d); check("rst_status", d, 32'h2);
    bus_rd(16'h0030, d); check("unmapped_read", d, 0);

    // Sweep 1: three points of constant (+100, -50), four averages
    quad_mode = 0; q1_set = 24'sd100; q2_set = -24'sd50;
    configure(1000, 10, 3, 4, 2);
    bus_rd(A_START, d); check("start_readback", d, 1000);
    plan_sweep(1000, 10, 3, 4);
    p0 = pulse_cnt;
    bus_wr(A_CTRL, 1);
    check("busy_after_start", busy, 1);
    wait_idle(200);
    check("s1_pulses", pulse_cnt - p0, 3);
    check("s1_freqs_done", exp_freq.size(), 0);
    bus_rd(A_STAT, d); check("s1_status", d, 32'd12);
    bus_rd(A_FI, d); check("s1_i_lit", d, 32'd400); check("s1_i_model", d, exp_i.pop_front());
    bus_rd(A_FQ, d); check("s1_q_lit", d, 32'hFFFF_FF38); check("s1_q_model", d, exp_q.pop_front());
    pop_check(); pop_check();
    bus_rd(A_STAT, d); check("s1_empty", d, 32'h2);
    bus_rd(A_FI, d); check("empty_peek", d, 0);
    bus_rd(A_FQ, d); check("empty_pop", d, 0);

    // Settling: 5 sleep cycles, one sample taken 6 edges after the pulse edge
    quad_mode = 1; q2_set = 24'sd7;
    configure(2000, 5, 1, 1, 5);
    exp_freq.push_back(2000);
    b0 = busy_cnt;
    bus_wr(A_CTRL, 1);
    wait_idle(100);
    check("timing_busy_cycles", busy_cnt - b0, 8);
    bus_rd(A_FI, d); check("timing_sample", d, pulse_tick + 5);
    bus_rd(A_FQ, d); check("timing_q", d, 32'd7);

    // Full FIFO: 20 points, no reads until the sweep stalls
    quad_mode = 2;
    configure(100, 7, 20, 2, 1);
    plan_sweep(100, 7, 20, 2);
    bus_wr(A_CTRL, 1);
    repeat (150) @(negedge clk);
    bus_rd(A_CTRL, d); check("stall_ctrl", d, 32'h3);
    bus_rd(A_STAT, d); check("stall_status", d, 32'h41);
    check("stall_point", exp_freq.size(), 3);
    bus_rd(A_FI, d); check("full_i_lit", d, 32'd200); check("full_i_model", d, exp_i.pop_front());
    bus_rd(A_FQ, d); check("full_q_lit", d, 32'hFFFF_FF38); check("full_q_model", d, exp_q.pop_front());
    bus_rd(A_STAT, d); check("refill_status", d, 32'h41);
    while (exp_i.size() > 0) pop_check();
    wait_idle(200);
    bus_rd(A_CTRL, d); check("overflow_sticky", d, 32'h1);
    bus_rd(A_STAT, d); check("full_drained", d, 32'h2);

    // Saturation at both rails, then the largest unsaturated positive sum
    quad_mode = 0; q1_set = 24'sh7FFFFF; q2_set = 24'sh800000;
    configure(0, 0, 1, 512, 0);
    plan_sweep(0, 0, 1, 512);
    bus_wr(A_CTRL, 1);
    wait_idle(700);
    bus_rd(A_FI, d); check("sat_pos", d, 32'h7FFF_FFFF); check("sat_pos_model", d, exp_i.pop_front());
    bus_rd(A_FQ, d); check("sat_neg", d, 32'h8000_0000); check("sat_neg_model", d, exp_q.pop_front());
    bus_wr(A_AVG, 256);
    plan_sweep(0, 0, 1, 256);
    bus_wr(A_CTRL, 1);
    wait_idle(400);
    bus_rd(A_FI, d); check("nosat_pos", d, 32'h7FFF_FF00); check("nosat_pos_model", d, exp_i.pop_front());
    bus_rd(A_FQ, d); check("nosat_neg", d, 32'h8000_0000); check("nosat_neg_model", d, exp_q.pop_front());

    // points = 0 is ignored
    configure(50, 1, 0, 1, 0);
    b0 = busy_cnt; p0 = pulse_cnt;
    bus_wr(A_CTRL, 1);
    repeat (5) @(negedge clk);
    check("zero_pts_busy", busy_cnt - b0, 0);
    check("zero_pts_pulse", pulse_cnt - p0, 0);

    // averages = 0 accumulates exactly one sample
    q1_set = 24'sd9; q2_set = -24'sd9;
    configure(300, 1, 1, 0, 0);
    plan_sweep(300, 1, 1, 0);
    bus_wr(A_CTRL, 1);
    wait_idle(50);
    bus_rd(A_FI, d); check("avg0_i_lit", d, 32'd9);
    bus_rd(A_FQ, d); check("avg0_q_lit", d, 32'hFFFF_FFF7);
    void'(exp_i.pop_front()); void'(exp_q.pop_front());

    // Frequency wraps modulo 2^32 and holds after the sweep
    configure(32'hFFFF_FFF0, 32'h20, 2, 1, 0);
    plan_sweep(32'hFFFF_FFF0, 32'h20, 2, 1);
    bus_wr(A_CTRL, 1);
    wait_idle(50);
    check("wrap_hold", phase_inc, 32'h10);
    pop_check(); pop_check();

    // Abort during AVERAGE
    configure(500, 1, 2, 50, 0);
    exp_freq.push_back(500);
    bus_wr(A_CTRL, 1);
    repeat (10) @(negedge clk);
    bus_wr(A_CTRL, 2);
    check("abort_busy", busy, 0);
    bus_rd(A_STAT, d); check("abort_no_push", d, 32'h2);
    check("abort_phase_hold", phase_inc, 500);
    check("abort_freqs_done", exp_freq.size(), 0);

    // Reset in the middle of a sweep with entries queued
    mon_en = 1'b0;
    configure(10, 1, 5, 1, 0);
    bus_wr(A_CTRL, 1);
    repeat (12) @(negedge clk);
    rstn = 1'b0; addr = A_STAT; ren = 1'b1;
    @(negedge clk);
    check("mid_rst_phase", phase_inc, 0);
    check("mid_rst_pulse", freq_update, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rdata", rdata, 0);
    ren = 1'b0; rstn = 1'b1;
    bus_rd(A_STAT, d); check("mid_rst_fifo", d, 32'h2);
    mon_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
